// File: rtl/dram_dqs_rx_pkg.sv
// Shared encodings and widths for the DQS read-capture gate.
package dram_dqs_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LAT   = 3'd1,
    ST_PRE   = 3'd2,
    ST_BURST = 3'd3,
    ST_POST  = 3'd4
  } rx_state_e;

  localparam int PEND_MAX = 3;
  localparam int PEND_W   = 2;
  localparam int LAT_W    = 4;
  localparam int EDGE_W   = 4;
  localparam int TMO_W    = 8;
  localparam int STAT_W   = 8;

endpackage

// File: rtl/dram_dqs_rx_tmo.sv
// Missing-strobe watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TMO-th consecutive edge-less cycle is reached.
module dram_dqs_rx_tmo
  import dram_dqs_rx_pkg::*;
#(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] ctr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)      ctr <= '0;
    else if (clr)    ctr <= '0;
    else if (en)     ctr <= ctr + TMO_W'(1);
  end

  // A clear in the same cycle (a strobe edge) always beats expiry.
  assign expire = en & ~clr & (ctr == TMO_W'(TMO - 1));

endmodule

// File: rtl/dram_dqs_rx_gate.sv
// Read-direction DQS gate: latency wait, preamble/burst edge counting, completion
// or timeout, with up to PEND_MAX queued reads. Optional timeout statistics
// counter is built when DQS_RX_TMO_STATS_EN is defined.
module dram_dqs_rx_gate
  import dram_dqs_rx_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int TMO       = 15
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             dram_io_channel_disabled,
  input  logic             rd_start,
  input  logic [LAT_W-1:0] rd_lat,
  input  logic             dqs_in,
  output logic             dqs_gate,
  output logic             dqs_edge,
  output logic             rd_done,
  output logic             rd_tmo,
  output logic             busy,
  output logic             ovf_err,
  output logic [7:0]       tmo_cnt
);

  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(BURST_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  rx_state_e          state, state_n;
  logic [LAT_W-1:0]   lat_cnt, lat_n;
  logic [EDGE_W-1:0]  edge_cnt, edge_n;
  logic [PEND_W-1:0]  pend, pend_n;
  logic               dqs_q, rise;
  logic               edge_pulse_n, tmo_pulse_n, ovf_n, dispatch;
  logic               tmo_en, tmo_clr, tmo_expire;

  assign rise = dqs_in & ~dqs_q;

  assign tmo_en  = (state == ST_PRE) || (state == ST_BURST);
  assign tmo_clr = rise | ~tmo_en;

  dram_dqs_rx_tmo #(.TMO(TMO)) u_tmo (
    .clk    (clk),
    .rst_l  (rst_l),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      edge_cnt <= '0;
      pend     <= '0;
      dqs_q    <= 1'b0;
      dqs_edge <= 1'b0;
      rd_tmo   <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state    <= state_n;
      lat_cnt  <= lat_n;
      edge_cnt <= edge_n;
      pend     <= pend_n;
      dqs_q    <= dqs_in;
      dqs_edge <= edge_pulse_n;
      rd_tmo   <= tmo_pulse_n;
      ovf_err  <= ovf_n;
    end
  end

  always_comb begin
    state_n      = state;
    lat_n        = lat_cnt;
    edge_n       = edge_cnt;
    pend_n       = pend;
    edge_pulse_n = 1'b0;
    tmo_pulse_n  = 1'b0;
    ovf_n        = ovf_err;
    dispatch     = 1'b0;

    case (state)
      ST_IDLE: if (rd_start) begin
        state_n = ST_LAT;
        lat_n   = rd_lat;
      end
      ST_LAT: begin
        if (lat_cnt == '0) state_n = ST_PRE;
        else               lat_n   = lat_cnt - LAT_W'(1);
      end
      ST_PRE: begin
        if (rise) begin
          state_n      = ST_BURST;
          edge_n       = EDGE_W'(1);
          edge_pulse_n = 1'b1;
        end else if (tmo_expire) begin
          tmo_pulse_n = 1'b1;
          dispatch    = 1'b1;
        end
      end
      ST_BURST: begin
        if (rise) begin
          edge_n       = edge_cnt + EDGE_W'(1);
          edge_pulse_n = 1'b1;
          if (edge_cnt == LAST_EDGE) state_n = ST_POST;
        end else if (tmo_expire) begin
          tmo_pulse_n = 1'b1;
          dispatch    = 1'b1;
        end
      end
      ST_POST:  dispatch = 1'b1;
      default:  state_n  = ST_IDLE;
    endcase

    // A start arriving on a dispatch cycle is consumed directly, leaving pend as is.
    if (dispatch) begin
      if (rd_start || pend != '0) begin
        state_n = ST_LAT;
        lat_n   = rd_lat;
        if (!rd_start) pend_n = pend - PEND_W'(1);
      end else begin
        state_n = ST_IDLE;
      end
    end else if (state != ST_IDLE && rd_start) begin
      if (pend == PEND_FULL) ovf_n  = 1'b1;
      else                   pend_n = pend + PEND_W'(1);
    end

    if (dram_io_channel_disabled) begin
      state_n      = ST_IDLE;
      lat_n        = '0;
      edge_n       = '0;
      pend_n       = '0;
      edge_pulse_n = 1'b0;
      tmo_pulse_n  = 1'b0;
      ovf_n        = ovf_err;
    end
  end

  assign dqs_gate = (state == ST_PRE) || (state == ST_BURST) || (state == ST_POST);
  assign rd_done  = (state == ST_POST);
  assign busy     = (state != ST_IDLE);

`ifdef DQS_RX_TMO_STATS_EN
  logic [STAT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                           tmo_cnt_q <= '0;
    else if (tmo_pulse_n && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + STAT_W'(1);
  end

  assign tmo_cnt = tmo_cnt_q;
`else
  assign tmo_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dram_dqs_rx_gate.sv
// Directed bench for dram_dqs_rx_gate (BURST_LEN=4, TMO=15).
module tb_dram_dqs_rx_gate;

  logic       clk;
  logic       rst_l;
  logic       dram_io_channel_disabled;
  logic       rd_start;
  logic [3:0] rd_lat;
  logic       dqs_in;
  logic       dqs_gate, dqs_edge, rd_done, rd_tmo, busy, ovf_err;
  logic [7:0] tmo_cnt;

  int tests = 0;
  int fails = 0;
  int n_edge = 0;
  int n_done = 0;
  int n_tmo  = 0;

  dram_dqs_rx_gate #(.BURST_LEN(4), .TMO(15)) dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .dram_io_channel_disabled (dram_io_channel_disabled),
    .rd_start                 (rd_start),
    .rd_lat                   (rd_lat),
    .dqs_in                   (dqs_in),
    .dqs_gate                 (dqs_gate),
    .dqs_edge                 (dqs_edge),
    .rd_done                  (rd_done),
    .rd_tmo                   (rd_tmo),
    .busy                     (busy),
    .ovf_err                  (ovf_err),
    .tmo_cnt                  (tmo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n_edge += int'(dqs_edge);
    n_done += int'(rd_done);
    n_tmo  += int'(rd_tmo);
  endtask

  task automatic clr_cnt();
    n_edge = 0;
    n_done = 0;
    n_tmo  = 0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      dqs_in = 1'b1;
      tick();
      dqs_in = 1'b0;
      tick();
    end
  endtask

  task automatic wait_gate(input string tag);
    int k;
    k = 0;
    while (!dqs_gate && k < 50) begin
      tick();
      k++;
    end
    chk(tag, dqs_gate, 1);
  endtask

  task automatic run_burst(input string tag);
    wait_gate(tag);
    pulses(4);
  endtask

  initial begin
    rst_l = 1'b0;
    dram_io_channel_disabled = 1'b0;
    rd_start = 1'b0;
    rd_lat = 4'd0;
    dqs_in = 1'b0;
    #12;
    chk("rst_gate", dqs_gate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_tmo",  rd_tmo, 0);
    chk("rst_ovf",  ovf_err, 0);
    chk("rst_tmo_cnt", tmo_cnt, 0);
    rst_l = 1'b1;
    tick();

    // Nominal burst, rd_lat=2, start in T0.
    clr_cnt();
    rd_lat = 4'd2;
    rd_start = 1'b1;
    tick();                                   // T1
    rd_start = 1'b0;
    chk("t1_busy_lat", busy, 1);
    chk("t1_gate_lat", dqs_gate, 0);
    tick(); tick();                           // T3
    chk("t1_gate_T3", dqs_gate, 0);
    tick();                                   // T4
    chk("t1_gate_T4", dqs_gate, 1);
    tick();                                   // T5
    dqs_in = 1'b1;
    tick();                                   // T6
    chk("t1_edge_T6", dqs_edge, 1);
    dqs_in = 1'b0; tick();
    dqs_in = 1'b1; tick();
    dqs_in = 1'b0; tick();
    dqs_in = 1'b1; tick();
    dqs_in = 1'b0; tick();                    // T11
    dqs_in = 1'b1; tick();                    // T12
    chk("t1_done_T12", rd_done, 1);
    chk("t1_gate_post", dqs_gate, 1);
    dqs_in = 1'b0; tick();                    // T13
    chk("t1_busy_after", busy, 0);
    chk("t1_gate_after", dqs_gate, 0);
    chk("t1_n_edge", n_edge, 4);
    chk("t1_n_done", n_done, 1);
    chk("t1_n_tmo",  n_tmo, 0);

    // Timeout: rd_lat=0, PRE entered at T2, rd_tmo at T17.
    clr_cnt();
    rd_lat = 4'd0;
    rd_start = 1'b1;
    tick();                                   // T1
    rd_start = 1'b0;
    tick();                                   // T2
    chk("t2_gate_pre", dqs_gate, 1);
    repeat (14) tick();                       // T16
    chk("t2_no_tmo_T16", rd_tmo, 0);
    chk("t2_busy_T16", busy, 1);
    tick();                                   // T17
    chk("t2_tmo_T17", rd_tmo, 1);
    chk("t2_idle_T17", busy, 0);
    tick();
    chk("t2_tmo_pulse", rd_tmo, 0);
    chk("t2_n_tmo", n_tmo, 1);
    chk("t2_n_done", n_done, 0);
`ifdef DQS_RX_TMO_STATS_EN
    chk("t2_tmo_cnt", tmo_cnt, 1);
`else
    chk("t2_tmo_cnt", tmo_cnt, 0);
`endif

    // Queue: one start plus four while busy; last one overflows.
    clr_cnt();
    rd_lat = 4'd1;
    rd_start = 1'b1;
    repeat (4) tick();
    chk("t3_ovf_pre", ovf_err, 0);
    tick();
    chk("t3_ovf_set", ovf_err, 1);
    rd_start = 1'b0;
    for (int b = 0; b < 4; b++) run_burst("t3_gate");
    tick(); tick();
    chk("t3_n_done", n_done, 4);
    chk("t3_idle", busy, 0);
    chk("t3_ovf_sticky", ovf_err, 1);

    // Start coincident with POST: straight to LAT, pend unchanged.
    clr_cnt();
    rd_lat = 4'd0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_gate("t4_gate1");
    pulses(3);
    dqs_in = 1'b1;
    tick();
    chk("t4_post", rd_done, 1);
    rd_start = 1'b1;
    dqs_in = 1'b0;
    tick();
    rd_start = 1'b0;
    chk("t4_lat_busy", busy, 1);
    chk("t4_lat_gate", dqs_gate, 0);
    run_burst("t4_gate2");
    chk("t4_idle", busy, 0);
    chk("t4_n_done", n_done, 2);

    // Channel disable mid-burst with one read queued.
    rd_lat = 4'd0;
    rd_start = 1'b1;
    tick(); tick();
    rd_start = 1'b0;
    wait_gate("t5_gate");
    pulses(2);
    clr_cnt();
    dram_io_channel_disabled = 1'b1;
    tick();
    chk("t5_dis_busy", busy, 0);
    chk("t5_dis_gate", dqs_gate, 0);
    rd_start = 1'b1;
    tick();
    chk("t5_dis_ignore", busy, 0);
    rd_start = 1'b0;
    dram_io_channel_disabled = 1'b0;
    repeat (20) tick();
    chk("t5_n_done", n_done, 0);
    chk("t5_n_tmo", n_tmo, 0);
    chk("t5_ovf_kept", ovf_err, 1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    run_burst("t5_gate2");
    chk("t5_pend_flushed", busy, 0);

    // Rise during LAT is ignored.
    clr_cnt();
    rd_lat = 4'd3;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    dqs_in = 1'b1; tick();
    dqs_in = 1'b0; tick();
    chk("t6_lat_no_edge", dqs_edge, 0);
    run_burst("t6_gate");
    chk("t6_n_edge", n_edge, 4);
    chk("t6_n_done", n_done, 1);

    // Async reset mid-burst, then DQS glitch while idle.
    rd_lat = 4'd0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_gate("t7_gate");
    pulses(1);
    dqs_in = 1'b1;
    tick();
    chk("t7_edge_before", dqs_edge, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("t7_rst_gate", dqs_gate, 0);
    chk("t7_rst_edge", dqs_edge, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_ovf",  ovf_err, 0);
    chk("t7_rst_tmo_cnt", tmo_cnt, 0);
    dqs_in = 1'b0;
    rst_l = 1'b1;
    tick();
    clr_cnt();
    dqs_in = 1'b1; tick();
    dqs_in = 1'b0; tick();
    chk("t7_idle_glitch", n_edge, 0);
    chk("t7_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
